// File: rtl/game_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | game_fsm: button debounce, NEWGAME/PLAY/PAUSE/OVER sequencing with a     |
// | tick-based play timer, and a registered pixel colour multiplexer.        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module game_fsm #(
  parameter int TICK_DIV   = 100000000,
  parameter int GAME_TICKS = 60,
  parameter int OVER_TICKS = 5,
  parameter int TW         = 13,
  parameter int NBTN       = 3,
  parameter int DB_CYCLES  = 1000000,
  parameter int PAUSE_EN   = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            p_tick,
  input  logic            video_on,
  input  logic [NBTN-1:0] btn,
  input  logic            btn_pause,
  input  logic [3:0]      text_on,
  input  logic [11:0]     text_rgb,
  input  logic            graph_on,
  input  logic [11:0]     graph_rgb,
  output logic [1:0]      state,
  output logic            game_run,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_pulse,
  output logic [TW-1:0]   timer_val,
  output logic [3:0]      red,
  output logic [3:0]      green,
  output logic [3:0]      blue
);

  localparam int NB  = NBTN + 1;
  localparam int DCW = $clog2(DB_CYCLES + 1);
  localparam int DW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OW  = (OVER_TICKS > 1) ? $clog2(OVER_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    PAUSE   = 2'b10,
    OVER    = 2'b11
  } state_t;

  logic [NB-1:0] raw;
  logic [NB-1:0] pulse;
  logic          pause_pulse;

  assign raw = {btn_pause, btn};

  // Channel NBTN is the pause button; only its pulse leaves the generate.
  for (genvar i = 0; i < NB; i++) begin : g_db
    logic           sync1;
    logic           sync2;
    logic           lvl;
    logic           pls;
    logic [DCW-1:0] cnt;

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
        lvl   <= 1'b0;
        pls   <= 1'b0;
        cnt   <= '0;
      end else begin
        sync1 <= raw[i];
        sync2 <= sync1;
        pls   <= 1'b0;
        if (sync2 == lvl) begin
          cnt <= '0;
        end else if (cnt == DCW'(DB_CYCLES - 1)) begin
          cnt <= '0;
          lvl <= sync2;
          pls <= sync2;
        end else begin
          cnt <= cnt + DCW'(1);
        end
      end
    end

    assign pulse[i] = pls;

    if (i < NBTN) begin : g_lvl
      assign btn_level[i] = lvl;
    end
  end

  assign btn_pulse   = pulse[NBTN-1:0];
  assign pause_pulse = pulse[NBTN] && (PAUSE_EN != 0);

  state_t        cur, nxt;
  logic [DW-1:0] div, div_nxt;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [OW-1:0] ocnt, ocnt_nxt;
  logic          tick;

  assign tick = (div == DW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cur  <= NEWGAME;
      div  <= '0;
      tmr  <= '0;
      ocnt <= '0;
    end else begin
      cur  <= nxt;
      div  <= div_nxt;
      tmr  <= tmr_nxt;
      ocnt <= ocnt_nxt;
    end
  end

  always_comb begin
    nxt      = cur;
    div_nxt  = div;
    tmr_nxt  = tmr;
    ocnt_nxt = ocnt;
    case (cur)
      NEWGAME: begin
        if (|btn_pulse) begin
          nxt     = PLAY;
          tmr_nxt = TW'(GAME_TICKS);
          div_nxt = '0;
        end
      end
      PLAY: begin
        div_nxt = tick ? '0 : div + DW'(1);
        if (tick) begin
          if (tmr <= TW'(1)) begin
            // Expiry takes precedence over a simultaneous pause request.
            nxt      = OVER;
            tmr_nxt  = '0;
            div_nxt  = '0;
            ocnt_nxt = '0;
          end else begin
            tmr_nxt = tmr - TW'(1);
          end
        end
        if (nxt == PLAY && pause_pulse) begin
          nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (pause_pulse) begin
          nxt = PLAY;
        end
      end
      OVER: begin
        tmr_nxt = '0;
        div_nxt = tick ? '0 : div + DW'(1);
        if (tick) begin
          if (ocnt == OW'(OVER_TICKS - 1)) begin
            nxt      = NEWGAME;
            ocnt_nxt = '0;
          end else begin
            ocnt_nxt = ocnt + OW'(1);
          end
        end
      end
    endcase
  end

  assign state     = cur;
  assign game_run  = (cur == PLAY);
  assign timer_val = tmr;

  logic        txt_hit;
  logic [11:0] pix;
  logic [11:0] rgb;

  always_comb begin
    txt_hit = 1'b0;
    case (cur)
      NEWGAME:     txt_hit = text_on[1] | text_on[2];
      PLAY, PAUSE: txt_hit = text_on[0];
      OVER:        txt_hit = text_on[3];
    endcase
  end

  always_comb begin
    pix = '0;
    if (video_on) begin
      if (txt_hit) begin
        pix = text_rgb;
      end else if (graph_on && cur == PLAY) begin
        pix = graph_rgb;
      end else if (graph_on && cur == PAUSE) begin
        pix = {1'b0, graph_rgb[11:9], 1'b0, graph_rgb[7:5], 1'b0, graph_rgb[3:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb <= '0;
    end else if (p_tick) begin
      rgb <= pix;
    end
  end

  assign red   = rgb[11:8];
  assign green = rgb[7:4];
  assign blue  = rgb[3:0];

endmodule
`default_nettype wire

// File: tb/tb_game_fsm.sv
`default_nettype none
// Directed self-checking bench for game_fsm with small timing parameters.
module tb_game_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_tick;
  logic        video_on;
  logic [2:0]  btn;
  logic        btn_pause;
  logic [3:0]  text_on;
  logic [11:0] text_rgb;
  logic        graph_on;
  logic [11:0] graph_rgb;
  logic [1:0]  state;
  logic        game_run;
  logic [2:0]  btn_level;
  logic [2:0]  btn_pulse;
  logic [12:0] timer_val;
  logic [3:0]  red, green, blue;

  int checks   = 0;
  int failures = 0;
  logic [2:0] seen;

  game_fsm #(
    .TICK_DIV(4), .GAME_TICKS(3), .OVER_TICKS(2), .TW(13),
    .NBTN(3), .DB_CYCLES(3), .PAUSE_EN(1)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .video_on(video_on),
    .btn(btn), .btn_pause(btn_pause), .text_on(text_on), .text_rgb(text_rgb),
    .graph_on(graph_on), .graph_rgb(graph_rgb), .state(state), .game_run(game_run),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .timer_val(timer_val),
    .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; p_tick = 1'b0; video_on = 1'b0; btn = '0; btn_pause = 1'b0;
    text_on = '0; text_rgb = '0; graph_on = 1'b0; graph_rgb = '0;
    step(3);
    reset = 1'b0;
    check("rst_state", state, 2'b00);
    check("rst_timer", timer_val, 0);
    check("rst_rgb", {red, green, blue}, 12'h000);
    check("rst_run", game_run, 1'b0);
    check("rst_level", btn_level, 3'b000);
    check("rst_pulse", btn_pulse, 3'b000);
    step(1);
    check("idle_state", state, 2'b00);

    // NEWGAME title text wins; score text and graphics do not show here
    video_on = 1'b1; text_on = 4'b0010; text_rgb = 12'h5A5; p_tick = 1'b1;
    step(1);
    check("ng_title_rgb", {red, green, blue}, 12'h5A5);
    text_on = 4'b0001; graph_on = 1'b1; graph_rgb = 12'hFFF;
    step(1);
    check("ng_graph_rgb", {red, green, blue}, 12'h000);
    p_tick = 1'b0; video_on = 1'b0; text_on = '0; graph_on = 1'b0;

    // Two-cycle glitch must not produce a pulse
    btn = 3'b001;
    step(2);
    btn = 3'b000;
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      seen = seen | btn_pulse;
    end
    check("glitch_pulse", seen, 3'b000);
    check("glitch_level", btn_level, 3'b000);
    check("glitch_state", state, 2'b00);

    // Held press: pulse exactly at the fifth edge
    btn = 3'b001;
    step(4);
    check("db_early_pulse", btn_pulse, 3'b000);
    step(1);
    check("db_pulse", btn_pulse, 3'b001);
    check("db_level", btn_level, 3'b001);
    check("db_pulse_state", state, 2'b00);
    step(1);
    check("db_pulse_once", btn_pulse, 3'b000);
    check("b_play_state", state, 2'b01);
    check("b_play_timer", timer_val, 3);
    check("b_play_run", game_run, 1'b1);
    btn = 3'b000;
    step(4);
    check("b_timer2", timer_val, 2);
    video_on = 1'b1; graph_on = 1'b1; graph_rgb = 12'hABC; p_tick = 1'b1;
    step(1);
    check("play_graph_rgb", {red, green, blue}, 12'hABC);
    check("b_timer2_hold", timer_val, 2);
    reset = 1'b1;
    step(1);
    check("midrst_state", state, 2'b00);
    check("midrst_timer", timer_val, 0);
    check("midrst_rgb", {red, green, blue}, 12'h000);
    check("midrst_run", game_run, 1'b0);
    check("midrst_level", btn_level, 3'b000);
    reset = 1'b0; video_on = 1'b0; graph_on = 1'b0; p_tick = 1'b0;

    // Full game with btn[1]
    btn = 3'b010;
    step(5);
    check("c_pulse", btn_pulse, 3'b010);
    step(1);
    check("c_state_play", state, 2'b01);
    check("c_timer3", timer_val, 3);
    btn = 3'b000;
    step(3);
    check("c_timer3_hold", timer_val, 3);
    step(1);
    check("c_timer2", timer_val, 2);
    step(4);
    check("c_timer1", timer_val, 1);
    step(3);
    check("c_pre_over", state, 2'b01);
    step(1);
    check("c_over_state", state, 2'b11);
    check("c_over_timer", timer_val, 0);
    check("c_over_run", game_run, 1'b0);
    step(7);
    check("c_over_hold", state, 2'b11);
    step(1);
    check("c_newgame", state, 2'b00);
    check("c_newgame_timer", timer_val, 0);

    // Pause after 6 PLAY cycles, 20 cycles paused, resume
    btn = 3'b100;
    step(6);
    check("d_play", state, 2'b01);
    btn = 3'b000; btn_pause = 1'b1;
    step(5);
    check("d_pre_pause", state, 2'b01);
    step(1);
    check("d_pause", state, 2'b10);
    check("d_pause_timer", timer_val, 2);
    check("d_pause_run", game_run, 1'b0);
    btn_pause = 1'b0; btn = 3'b001;
    step(6);
    check("d_btn_ignored", state, 2'b10);
    check("d_btn_level", btn_level, 3'b001);
    btn = 3'b000;
    step(8);
    check("d_pause_hold", state, 2'b10);
    check("d_frozen_timer", timer_val, 2);
    btn_pause = 1'b1;
    step(5);
    check("d_still_paused", state, 2'b10);
    btn_pause = 1'b0;
    step(1);
    check("d_resume", state, 2'b01);
    check("d_resume_timer", timer_val, 2);
    step(5);
    check("d_timer1", timer_val, 1);
    check("d_pre_over", state, 2'b01);
    step(1);
    check("d_over", state, 2'b11);
    check("d_over_timer", timer_val, 0);
    step(8);
    check("d_newgame", state, 2'b00);

    // Pause pulse lands on the expiry cycle
    btn = 3'b001;
    step(6);
    check("e_play", state, 2'b01);
    btn = 3'b000;
    step(6);
    btn_pause = 1'b1;
    step(5);
    check("e_pre_expiry", state, 2'b01);
    check("e_timer1", timer_val, 1);
    step(1);
    check("e_expiry_over", state, 2'b11);
    check("e_expiry_timer", timer_val, 0);
    btn_pause = 1'b0;
    step(1);
    check("e_over_hold", state, 2'b11);
    step(7);
    check("e_newgame", state, 2'b00);

    // PAUSE colour path
    btn = 3'b010;
    step(6);
    check("f_play", state, 2'b01);
    btn = 3'b000; btn_pause = 1'b1;
    step(6);
    check("f_pause", state, 2'b10);
    btn_pause = 1'b0;
    video_on = 1'b1; graph_on = 1'b1; graph_rgb = 12'hF84; text_on = 4'b0000; p_tick = 1'b1;
    step(1);
    check("f_dim_rgb", {red, green, blue}, 12'h742);
    p_tick = 1'b0; graph_rgb = 12'h0FF;
    step(1);
    check("f_hold_rgb", {red, green, blue}, 12'h742);
    p_tick = 1'b1; text_on = 4'b0001; text_rgb = 12'h123;
    step(1);
    check("f_score_rgb", {red, green, blue}, 12'h123);
    video_on = 1'b0;
    step(1);
    check("f_blank_rgb", {red, green, blue}, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_fsm.md
GAME_FSM -- requirements
Module: game_fsm

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, clk cycles per timer tick (1 s at 100 MHz).
REQ-002 SHALL have parameter GAME_TICKS, default 60, play duration in ticks.
REQ-003 SHALL have parameter OVER_TICKS, default 5, game-over screen duration in ticks.
REQ-004 SHALL have parameter TW, default 13, timer_val width; GAME_TICKS < 2^TW.
REQ-005 SHALL have parameter NBTN, default 3, number of game buttons.
REQ-006 SHALL have parameter DB_CYCLES, default 1000000, debounce stable-time in clk cycles.
REQ-007 SHALL have parameter PAUSE_EN, default 1; 0 removes the PAUSE state.
REQ-008 clk  input  1  single system clock; all logic on rising edge.
REQ-009 reset  input  1  synchronous, active-high.
REQ-010 p_tick  input  1  pixel strobe from VGA driver.
REQ-011 video_on  input  1  visible-area flag.
REQ-012 btn  input  NBTN  raw asynchronous game buttons.
REQ-013 btn_pause  input  1  raw asynchronous pause button.
REQ-014 text_on  input  4  text layer hits: [0] score, [1] title, [2] prompt, [3] over.
REQ-015 text_rgb  input  12  text colour {r,g,b}.
REQ-016 graph_on, graph_rgb  input  1/12  raycaster pixel valid and colour.
REQ-017 state  output  2  NEWGAME=00, PLAY=01, PAUSE=10, OVER=11.
REQ-018 game_run  output  1  high only in PLAY; enables movement/raycast updates.
REQ-019 btn_level, btn_pulse  output  NBTN each  debounced level and one-cycle rising-edge pulse.
REQ-020 timer_val  output  TW  remaining play ticks.
REQ-021 red, green, blue  output  4 each  registered pixel colour.

Function
REQ-022 Each raw button SHALL pass a 2-flop synchronizer, then a per-button counter; debounced level changes only after the synced input differs from it for DB_CYCLES consecutive cycles.
REQ-023 btn_pulse[i] SHALL be high exactly one cycle on each 0->1 of btn_level[i]; pause pulse internal, same rule.
REQ-024 NEWGAME: any btn_pulse -> PLAY; timer_val loaded GAME_TICKS, tick divider cleared on transition.
REQ-025 PLAY: divider counts 0..TICK_DIV-1; at wrap timer_val decrements by 1; when timer_val decrements to 0 -> OVER same cycle.
REQ-026 PLAY with pause pulse and PAUSE_EN=1 -> PAUSE; divider and timer_val frozen.
REQ-027 PAUSE: pause pulse -> PLAY, resuming divider from frozen value; game buttons ignored.
REQ-028 Timer expiry and pause pulse in same cycle: expiry wins, -> OVER.
REQ-029 OVER: divider cleared on entry; after OVER_TICKS ticks -> NEWGAME; timer_val holds 0; buttons ignored.
REQ-030 timer_val SHALL never underflow; holds value in NEWGAME.
REQ-031 Colour regs SHALL update only on p_tick, priority: !video_on -> 0; state-matched text (NEWGAME text_on[1]|[2]; PLAY/PAUSE text_on[0]; OVER text_on[3]) -> text_rgb; graph_on in PLAY -> graph_rgb; graph_on in PAUSE -> each channel graph_rgb>>1; else 0.
REQ-032 With PAUSE_EN=0, state SHALL never equal 10 and btn_pause is ignored.

Reset
REQ-033 reset SHALL force state=NEWGAME, timer_val=0, divider=0, debounce levels/counters/pulses=0, red=green=blue=0, game_run=0, from any state including mid-PLAY or PAUSE.
REQ-034 First rising edge after reset deasserts SHALL behave as NEWGAME with no pending pulses.

Verification (TICK_DIV=4, GAME_TICKS=3, OVER_TICKS=2, DB_CYCLES=3)
REQ-035 btn[0] high 2 cycles then low -> no btn_pulse; held high -> single btn_pulse[0] 5 cycles after assertion (2 sync + 3 stable).
REQ-036 Press btn[1] in NEWGAME -> state 01, timer_val 3; 2,1 at 4-cycle spacing; state 11 with timer_val 0 12 cycles after entry; state 00 8 cycles later.
REQ-037 Pause after 6 PLAY cycles, hold PAUSE 20 cycles, pause again -> timer_val unchanged during PAUSE; OVER reached 6 PLAY cycles after resume.
REQ-038 Pause pulse on expiry cycle -> state 11, not 10.
REQ-039 video_on=1, state PAUSE, graph_on=1, graph_rgb=12'hF84, text_on=0, p_tick -> {red,green,blue}=12'h742; no p_tick -> colours hold.
REQ-040 reset asserted mid-PLAY with timer_val 2 -> next cycle state 00, timer_val 0, colours 0, game_run 0.
